// File: rtl/mdio_mgr_pkg.sv
// Shared encodings for the MDIO PHY manager: op codes, PHY register numbers,
// FSM states and command owners.
package mdio_mgr_pkg;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_RD = 2'b10;

  localparam logic [4:0] BMCR = 5'd0;
  localparam logic [4:0] BMSR = 5'd1;
  localparam logic [4:0] ANAR = 5'd4;

  localparam int BMSR_LINK_BIT = 2;

  typedef enum logic [2:0] {
    S_INIT_ISSUE,
    S_ARB,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    OWN_INIT,
    OWN_POLL,
    OWN_HOST
  } owner_t;
endpackage

// File: rtl/mdio_init_rom.sv
// Fixed PHY bring-up list: index -> {register, write data}. Every entry is a write.
module mdio_init_rom
  import mdio_mgr_pkg::*;
(
  input  logic [2:0]  idx,
  output logic [4:0]  rom_reg,
  output logic [15:0] rom_data
);
  always_comb begin
    rom_reg  = BMCR;
    rom_data = 16'h0000;
    case (idx)
      3'd0: begin rom_reg = BMCR; rom_data = 16'h8000; end  // soft reset
      3'd1: begin rom_reg = ANAR; rom_data = 16'h01E1; end
      3'd2: begin rom_reg = BMCR; rom_data = 16'h1200; end  // AN enable + restart
      default: ;
    endcase
  end
endmodule

// File: rtl/mdio_phy_manager.sv
// Sequencer/arbiter in front of the MDIO master: init list, periodic BMSR poll, host port.
// Optional: define MDIO_LINK_IRQ_EN to get a one-cycle o_link_irq on every polled link change.
module mdio_phy_manager
  import mdio_mgr_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR    = 5'd1,
  parameter int         INIT_LEN    = 3,
  parameter int         POLL_PERIOD = 1_000_000,
  parameter int         OP_TIMEOUT  = 4096
) (
  input  logic        iclk_100m,
  input  logic        i_rst,
  input  logic        i_host_req,
  input  logic [1:0]  i_host_op,
  input  logic [4:0]  i_host_reg,
  input  logic [15:0] i_host_wdata,
  output logic        o_host_ack,
  output logic [15:0] o_host_rdata,
  output logic        o_host_err,
  output logic [1:0]  o_operation,
  output logic [4:0]  o_phy_addr,
  output logic [4:0]  o_reg_addr,
  output logic [15:0] o_master_write_data,
  output logic        o_operation_begin,
  input  logic [15:0] i_master_read_data,
  input  logic        i_master_read_data_valid,
  input  logic        i_operation_finish,
  input  logic        i_mdio_master_busy,
  output logic        o_init_done,
  output logic        o_link_up,
  output logic        o_err_sticky,
  input  logic        i_err_clr,
  output logic        o_link_irq
);
  localparam int TW  = $clog2(POLL_PERIOD + 1);
  localparam int TOW = $clog2(OP_TIMEOUT + 1);

  state_t          state, state_nxt;
  owner_t          owner;
  logic [2:0]      init_idx;
  logic            init_retry;
  logic [TW-1:0]   poll_tmr;
  logic            poll_pend;
  logic [TOW-1:0]  to_cnt;
  logic            to_fail, rd_vld, bad_op;
  logic [1:0]      guard, beg_cnt;
  logic [15:0]     rdata_q;
  logic [4:0]      rom_reg;
  logic [15:0]     rom_data;

  mdio_init_rom u_rom (.idx(init_idx), .rom_reg(rom_reg), .rom_data(rom_data));

  // ack gating stops a still-high level request from being served twice
  wire host_go   = i_host_req && o_init_done && !o_host_ack;
  wire host_bad  = (i_host_op != OP_WR) && (i_host_op != OP_RD);
  wire ready     = !i_mdio_master_busy && (guard == 2'd0);
  wire timed_out = (to_cnt == TOW'(OP_TIMEOUT - 1));
  wire last_init = (init_idx == 3'(INIT_LEN - 1));
  wire mdio_fail = !bad_op && (to_fail || ((o_operation == OP_RD) && !rd_vld));

  always_ff @(posedge iclk_100m) begin
    if (i_rst) state <= S_INIT_ISSUE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT_ISSUE: state_nxt = S_ISSUE;
      S_ARB: begin
        if (host_go)        state_nxt = host_bad ? S_DONE : S_ISSUE;
        else if (poll_pend) state_nxt = S_ISSUE;
      end
      S_ISSUE: if (beg_cnt == 2'd2) state_nxt = S_WAIT;
      S_WAIT:  if (i_operation_finish || timed_out) state_nxt = S_DONE;
      S_DONE: begin
        state_nxt = S_ARB;
        if (owner == OWN_INIT && ((mdio_fail && !init_retry) || !last_init))
          state_nxt = S_INIT_ISSUE;
      end
      default: state_nxt = S_INIT_ISSUE;
    endcase
  end

  always_ff @(posedge iclk_100m) begin
    if (i_rst) begin
      owner <= OWN_INIT;  init_idx <= '0;  init_retry <= 1'b0;
      poll_tmr <= '0;     poll_pend <= 1'b0;
      to_cnt <= '0;  to_fail <= 1'b0;  rd_vld <= 1'b0;  bad_op <= 1'b0;
      guard <= '0;   beg_cnt <= '0;    rdata_q <= '0;
      o_host_ack <= 1'b0;  o_host_rdata <= '0;  o_host_err <= 1'b0;
      o_operation <= '0;   o_phy_addr <= '0;    o_reg_addr <= '0;
      o_master_write_data <= '0;  o_operation_begin <= 1'b0;
      o_init_done <= 1'b0; o_link_up <= 1'b0;   o_err_sticky <= 1'b0;
    end else begin
      o_host_ack <= 1'b0;

      // finish-to-begin spacing the master needs between commands
      if (i_operation_finish)  guard <= 2'd2;
      else if (guard != 2'd0)  guard <= guard - 2'd1;

      if (state == S_INIT_ISSUE || state == S_ARB) begin
        beg_cnt <= '0;  to_cnt <= '0;  to_fail <= 1'b0;
        rd_vld  <= 1'b0; rdata_q <= '0;
      end

      case (state)
        S_INIT_ISSUE: begin
          owner <= OWN_INIT;  bad_op <= 1'b0;
          o_operation <= OP_WR;  o_phy_addr <= PHY_ADDR;
          o_reg_addr <= rom_reg; o_master_write_data <= rom_data;
        end
        S_ARB: begin
          if (host_go) begin
            owner <= OWN_HOST;  bad_op <= host_bad;
            o_operation <= i_host_op;  o_phy_addr <= PHY_ADDR;
            o_reg_addr <= i_host_reg;  o_master_write_data <= i_host_wdata;
          end else if (poll_pend) begin
            owner <= OWN_POLL;  bad_op <= 1'b0;  poll_pend <= 1'b0;
            o_operation <= OP_RD;  o_phy_addr <= PHY_ADDR;
            o_reg_addr <= BMSR;    o_master_write_data <= '0;
          end
        end
        S_ISSUE: begin
          // begin is held exactly two cycles; the master edge-detects it
          if (beg_cnt == 2'd0) begin
            if (ready) begin o_operation_begin <= 1'b1; beg_cnt <= 2'd1; end
          end else if (beg_cnt == 2'd1) begin
            beg_cnt <= 2'd2;
          end else begin
            o_operation_begin <= 1'b0;
          end
        end
        S_WAIT: begin
          to_cnt <= to_cnt + TOW'(1);
          if (i_master_read_data_valid) begin rdata_q <= i_master_read_data; rd_vld <= 1'b1; end
          if (timed_out && !i_operation_finish) to_fail <= 1'b1;
        end
        S_DONE: begin
          case (owner)
            OWN_INIT: begin
              if (mdio_fail && !init_retry) init_retry <= 1'b1;
              else begin
                init_retry <= 1'b0;
                if (last_init) o_init_done <= 1'b1;
                else           init_idx <= init_idx + 3'd1;
              end
            end
            OWN_POLL: if (!mdio_fail) o_link_up <= rdata_q[BMSR_LINK_BIT];
            default: begin
              o_host_ack <= 1'b1;  o_host_rdata <= rdata_q;
              o_host_err <= mdio_fail || bad_op;
            end
          endcase
        end
        default: ;
      endcase

      // placed after the ARB clear so a same-cycle wrap re-arms the poll
      if (o_init_done) begin
        if (poll_tmr == TW'(POLL_PERIOD - 1)) begin poll_tmr <= '0; poll_pend <= 1'b1; end
        else poll_tmr <= poll_tmr + TW'(1);
      end

      if (state == S_DONE && mdio_fail) o_err_sticky <= 1'b1;
      else if (i_err_clr)               o_err_sticky <= 1'b0;
    end
  end

`ifdef MDIO_LINK_IRQ_EN
  logic link_irq_q;
  always_ff @(posedge iclk_100m) begin
    if (i_rst) link_irq_q <= 1'b0;
    else link_irq_q <= (state == S_DONE) && (owner == OWN_POLL) && !mdio_fail &&
                       (rdata_q[BMSR_LINK_BIT] != o_link_up);
  end
  assign o_link_irq = link_irq_q;
`else
  assign o_link_irq = 1'b0;
`endif
endmodule

// File: tb/tb_mdio_phy_manager.sv
// Bench for mdio_phy_manager: transaction-level MDIO master + PHY register model,
// host-ack scoreboard, table-driven host accesses and hand-written corner sequences.
module tb_mdio_phy_manager;
  import mdio_mgr_pkg::*;
  localparam int PP = 2000;

  logic        iclk_100m = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_host_req = 1'b0;
  logic [1:0]  i_host_op = 2'b00;
  logic [4:0]  i_host_reg = 5'd0;
  logic [15:0] i_host_wdata = 16'h0;
  logic        o_host_ack, o_host_err, o_operation_begin, o_init_done, o_link_up;
  logic        o_err_sticky, o_link_irq;
  logic [15:0] o_host_rdata, o_master_write_data;
  logic [1:0]  o_operation;
  logic [4:0]  o_phy_addr, o_reg_addr;
  logic [15:0] m_rdat = 16'h0;
  logic        m_rvld = 1'b0, m_fin = 1'b0, m_busy = 1'b0;
  logic        i_err_clr = 1'b0;

  always #5 iclk_100m = ~iclk_100m;

  mdio_phy_manager #(.PHY_ADDR(5'd1), .INIT_LEN(3), .POLL_PERIOD(PP), .OP_TIMEOUT(256)) dut (
    .iclk_100m(iclk_100m), .i_rst(i_rst),
    .i_host_req(i_host_req), .i_host_op(i_host_op), .i_host_reg(i_host_reg),
    .i_host_wdata(i_host_wdata), .o_host_ack(o_host_ack), .o_host_rdata(o_host_rdata),
    .o_host_err(o_host_err), .o_operation(o_operation), .o_phy_addr(o_phy_addr),
    .o_reg_addr(o_reg_addr), .o_master_write_data(o_master_write_data),
    .o_operation_begin(o_operation_begin), .i_master_read_data(m_rdat),
    .i_master_read_data_valid(m_rvld), .i_operation_finish(m_fin),
    .i_mdio_master_busy(m_busy), .o_init_done(o_init_done), .o_link_up(o_link_up),
    .o_err_sticky(o_err_sticky), .i_err_clr(i_err_clr), .o_link_irq(o_link_irq)
  );

  typedef struct { logic [1:0] op; logic [4:0] rg; logic [15:0] wd; } mop_t;
  typedef struct { logic [15:0] rd; logic err; } hexp_t;
  typedef struct {
    logic [1:0] op; logic [4:0] rg; logic [15:0] wd;
    logic [15:0] exp_rd; logic exp_err; logic wr_chk; logic fast;
  } vec_t;

  int total = 0, bad = 0, cyc = 0;
  int poll_cnt = 0, last_poll_beg = 0, irq_cnt = 0, early_ack = 0, viol = 0;
  logic [15:0] phy [32];
  mop_t  log_q[$];
  hexp_t sb_q[$];
  mop_t  exp_init [3];
  logic  no_ta2 = 1'b0, beg_prev = 1'b0, beg_mon = 1'b0, busy_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_log(input string nm, input int idx, input mop_t e);
    if (idx < log_q.size())
      chk(nm, {9'd0, log_q[idx].op, log_q[idx].rg, log_q[idx].wd}, {9'd0, e.op, e.rg, e.wd});
    else begin
      total++; bad++;
      $display("FAIL %s: log has %0d entries, want entry %0d", nm, log_q.size(), idx);
    end
  endtask

  always @(posedge iclk_100m) cyc <= cyc + 1;

  // monitors: irq pulses, early acks, begin raised while master busy, host scoreboard
  always @(negedge iclk_100m) begin
    if (o_link_irq) irq_cnt <= irq_cnt + 1;
    if (o_host_ack && !o_init_done) early_ack <= early_ack + 1;
    if (o_operation_begin && !beg_mon && busy_prev) viol <= viol + 1;
    beg_mon   <= o_operation_begin;
    busy_prev <= m_busy;
    if (o_host_ack) begin
      if (sb_q.size() == 0) begin
        total++; bad++;
        $display("FAIL host ack: unexpected ack, rdata=%h", o_host_rdata);
      end else begin
        hexp_t e;
        e = sb_q.pop_front();
        chk("host rdata", o_host_rdata, e.rd);
        chk("host err", o_host_err, e.err);
      end
    end
  end

  // MDIO master + PHY model: 30-cycle transaction, finish pulse, optional missing turnaround
  initial begin
    forever begin
      @(posedge iclk_100m); #1;
      if (o_operation_begin && !beg_prev) begin
        mop_t t;
        t.op = o_operation; t.rg = o_reg_addr; t.wd = o_master_write_data;
        chk("phy addr", o_phy_addr, 5'd1);
        m_busy = 1'b1;
        if (t.op == OP_RD && t.rg == BMSR) last_poll_beg = cyc;
        repeat (30) @(posedge iclk_100m);
        #1;
        if (t.op == OP_RD) begin
          if (!(no_ta2 && t.rg == 5'd2)) begin m_rvld = 1'b1; m_rdat = phy[t.rg]; end
        end else phy[t.rg] = t.wd;
        m_fin = 1'b1;
        @(posedge iclk_100m); #1;
        m_fin = 1'b0; m_rvld = 1'b0; m_busy = 1'b0;
        log_q.push_back(t);
        if (t.op == OP_RD && t.rg == BMSR) poll_cnt++;
      end
      beg_prev = o_operation_begin;
    end
  end

  task automatic host_do(input logic [1:0] op, input logic [4:0] rg, input logic [15:0] wd,
                         input logic [15:0] erd, input logic eerr, output int lat);
    int n;
    sb_q.push_back('{erd, eerr});
    i_host_op = op; i_host_reg = rg; i_host_wdata = wd; i_host_req = 1'b1;
    n = 0;
    do begin @(negedge iclk_100m); n++; end while (!o_host_ack && n < 3000);
    chk("host ack seen", o_host_ack, 1'b1);
    if (!o_host_ack) sb_q.delete();
    i_host_req = 1'b0; i_err_clr = 1'b0;
    lat = n;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v [6];
    int lat, n, p0, n0, target, exp_irq;
    for (int i = 0; i < 32; i++) phy[i] = 16'h0;
    phy[1] = 16'h7849; phy[2] = 16'h0022; phy[3] = 16'hBEEF;
    exp_init[0] = '{OP_WR, 5'd0, 16'h8000};
    exp_init[1] = '{OP_WR, 5'd4, 16'h01E1};
    exp_init[2] = '{OP_WR, 5'd0, 16'h1200};
    v[0] = '{OP_RD, 5'd2, 16'h0,    16'h0022, 1'b0, 1'b0, 1'b0};
    v[1] = '{OP_WR, 5'd4, 16'h0061, 16'h0000, 1'b0, 1'b1, 1'b0};
    v[2] = '{OP_RD, 5'd4, 16'h0,    16'h0061, 1'b0, 1'b0, 1'b0};
    v[3] = '{2'b00, 5'd4, 16'h0,    16'h0000, 1'b1, 1'b0, 1'b1};
    v[4] = '{2'b11, 5'd3, 16'h0,    16'h0000, 1'b1, 1'b0, 1'b1};
    v[5] = '{OP_RD, 5'd3, 16'h0,    16'hBEEF, 1'b0, 1'b0, 1'b0};

    // reset state
    repeat (3) @(negedge iclk_100m);
    chk("reset outputs", {o_host_ack, o_host_err, o_host_rdata, o_operation, o_phy_addr,
                          o_reg_addr, o_master_write_data[5:0]}, 32'h0);
    chk("reset flags", {o_master_write_data[15:6], o_operation_begin, o_init_done,
                        o_link_up, o_err_sticky, o_link_irq}, 32'h0);

    // init list, host read pending from release must wait for it
    i_rst = 1'b0;
    host_do(OP_RD, 5'd2, 16'h0, 16'h0022, 1'b0, lat);
    chk("init done at host ack", o_init_done, 1'b1);
    chk("no early ack", early_ack, 0);
    for (int k = 0; k < 3; k++) chk_log("init write order", k, exp_init[k]);
    chk_log("host read after init", 3, '{OP_RD, 5'd2, 16'h0});

    // table-driven host accesses
    for (int k = 0; k < 6; k++) begin
      host_do(v[k].op, v[k].rg, v[k].wd, v[k].exp_rd, v[k].exp_err, lat);
      if (v[k].wr_chk) chk("phy reg written", phy[v[k].rg], v[k].wd);
      if (v[k].fast)   chk("bad op no mdio", lat <= 3, 1'b1);
    end

    // poll: link bit clear, then set
    for (int r = 0; r < 2; r++) begin
      if (r == 1) phy[1] = 16'h786D;
      p0 = poll_cnt; n = 0;
      while (poll_cnt == p0 && n < 2600) begin @(negedge iclk_100m); n++; end
      chk("poll seen", poll_cnt != p0, 1'b1);
      repeat (3) @(negedge iclk_100m);
      chk("link_up after poll", o_link_up, r[0]);
    end

    // host request lands on the cycle the next poll becomes pending
    target = last_poll_beg - 2 + PP;
    do begin @(posedge iclk_100m); #1; end while (cyc < target - 1);
    n0 = log_q.size(); p0 = poll_cnt;
    host_do(OP_WR, 5'd5, 16'h1234, 16'h0000, 1'b0, lat);
    n = 0;
    while (poll_cnt == p0 && n < 300) begin @(negedge iclk_100m); n++; end
    chk("held poll runs", poll_cnt != p0, 1'b1);
    chk_log("host first", n0, '{OP_WR, 5'd5, 16'h1234});
    chk_log("poll second", n0 + 1, '{OP_RD, BMSR, 16'h0});
    chk("phy reg5", phy[5], 16'h1234);

    // missing read data; clear held high through the failing op
    i_err_clr = 1'b1; @(negedge iclk_100m); i_err_clr = 1'b0; @(negedge iclk_100m);
    chk("sticky before fail", o_err_sticky, 1'b0);
    no_ta2 = 1'b1; i_err_clr = 1'b1;
    host_do(OP_RD, 5'd2, 16'h0, 16'h0000, 1'b1, lat);
    @(negedge iclk_100m);
    chk("sticky fail beats clr", o_err_sticky, 1'b1);
    no_ta2 = 1'b0;
    i_err_clr = 1'b1; @(negedge iclk_100m); i_err_clr = 1'b0; @(negedge iclk_100m);
    chk("sticky cleared", o_err_sticky, 1'b0);

    // reset during init entry 1
    n = 0;
    while (m_busy && n < 100) begin @(negedge iclk_100m); n++; end
    i_rst = 1'b1; repeat (2) @(negedge iclk_100m);
    log_q.delete(); i_rst = 1'b0;
    n = 0;
    while (!(log_q.size() == 1 && m_busy) && n < 500) begin @(negedge iclk_100m); n++; end
    chk("entry1 in flight", log_q.size() == 1 && m_busy, 1'b1);
    i_rst = 1'b1; repeat (3) @(negedge iclk_100m);
    chk("mid-op reset state", {o_init_done, o_link_up, o_operation_begin, o_host_ack}, 4'b0000);
    i_rst = 1'b0;
    n = 0;
    while (m_busy && n < 100) begin @(negedge iclk_100m); n++; end
    log_q.delete();
    n = 0;
    while (!o_init_done && n < 1000) begin @(negedge iclk_100m); n++; end
    chk("reinit done", o_init_done, 1'b1);
    chk("reinit write count", log_q.size(), 3);
    for (int k = 0; k < 3; k++) chk_log("reinit order", k, exp_init[k]);
    chk("begin only when idle", viol, 0);

`ifdef MDIO_LINK_IRQ_EN
    exp_irq = 1;
`else
    exp_irq = 0;
`endif
    chk("link irq count", irq_cnt, exp_irq);
    chk("host scoreboard drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
